// File: rtl/multiplication_576_8x10.sv
// Scales an 8x10 signed tile by 576, one element per cycle, through a
// multiply stage and a saturate/write stage, with a sticky overflow flag.
module multiplication_576_8x10 #(
  parameter int unsigned ROWS       = 8,
  parameter int unsigned COLS       = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SCALE      = 576
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow,
  input  logic signed [DATA_WIDTH-1:0] input_array  [ROWS][COLS],
  output logic signed [DATA_WIDTH-1:0] output_array [ROWS][COLS]
);

  localparam int unsigned PW    = DATA_WIDTH + 11;
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic signed [PW-1:0] SCALE_W = PW'(SCALE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_next;

  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;

  logic                   s1_valid;
  logic                   s1_last;
  logic [ROW_W-1:0]       s1_row;
  logic [COL_W-1:0]       s1_col;
  logic signed [PW-1:0]   s1_prod;

  logic accept_c, issue_c, last_issue_c, finish_c;
  logic signed [PW-1:0]         x_ext_c;
  logic [PW-DATA_WIDTH:0]       prod_upper_c;
  logic                         sat_c;
  logic signed [DATA_WIDTH-1:0] sat_val_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ISSUE;
      ISSUE:   if (row == LAST_ROW && col == LAST_COL) state_next = DRAIN;
      DRAIN:   if (s1_valid && s1_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control decodes
  always_comb begin
    accept_c     = 1'b0;
    issue_c      = 1'b0;
    last_issue_c = 1'b0;
    finish_c     = 1'b0;
    case (state)
      IDLE:  accept_c = start;
      ISSUE: begin
        issue_c      = 1'b1;
        last_issue_c = (row == LAST_ROW) && (col == LAST_COL);
      end
      DRAIN: finish_c = s1_valid && s1_last;
      default: ;
    endcase
  end

  // Row-major element index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (accept_c) begin
      row <= '0;
      col <= '0;
    end else if (issue_c) begin
      if (col == LAST_COL) begin
        col <= '0;
        row <= (row == LAST_ROW) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign x_ext_c = PW'(input_array[row][col]);

  // Stage 1: full-width signed product with its tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_row   <= '0;
      s1_col   <= '0;
      s1_prod  <= '0;
    end else begin
      s1_valid <= issue_c;
      if (issue_c) begin
        s1_last <= last_issue_c;
        s1_row  <= row;
        s1_col  <= col;
        s1_prod <= x_ext_c * SCALE_W;
      end
    end
  end

  // Product fits only if every bit above the result sign bit matches it
  always_comb begin
    prod_upper_c = s1_prod[PW-1:DATA_WIDTH-1];
    sat_c        = !((&prod_upper_c) || !(|prod_upper_c));
    if (!sat_c)
      sat_val_c = s1_prod[DATA_WIDTH-1:0];
    else if (s1_prod[PW-1])
      sat_val_c = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else
      sat_val_c = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  end

  // Stage 2: write-back plus handshake and sticky flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      for (int r = 0; r < int'(ROWS); r++)
        for (int c = 0; c < int'(COLS); c++)
          output_array[r][c] <= '0;
    end else begin
      done <= finish_c;
      if (accept_c) begin
        busy     <= 1'b1;
        overflow <= 1'b0;
      end else if (finish_c) begin
        busy <= 1'b0;
      end
      if (s1_valid) begin
        output_array[s1_row][s1_col] <= sat_val_c;
        if (sat_c) overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multiplication_576_8x10.sv
// Directed-plus-random bench for multiplication_576_8x10 against an
// arithmetic reference of scale-by-576 with 32-bit saturation.
module tb_multiplication_576_8x10;

  logic clk;
  logic rst_n;
  logic start;
  logic busy;
  logic done;
  logic overflow;
  logic signed [31:0] din  [8][10];
  logic signed [31:0] dout [8][10];

  logic signed [31:0] expv [8][10];
  logic exp_ovf;
  int compared;
  int mismatched;
  int lat;
  int bcnt;
  int done_cnt;
  int done_at;

  multiplication_576_8x10 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow),
    .input_array  (din),
    .output_array (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] scale_ref(input logic signed [31:0] x);
    longint p;
    p = longint'(x) * 64'sd576;
    if (p > 64'sd2147483647)  return 32'sh7FFFFFFF;
    if (p < -64'sd2147483648) return 32'sh80000000;
    return 32'(p);
  endfunction

  task automatic model_pass();
    exp_ovf = 1'b0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 10; c++) begin
        expv[r][c] = scale_ref(din[r][c]);
        if (longint'(din[r][c]) * 576 != longint'(expv[r][c])) exp_ovf = 1'b1;
      end
  endtask

  task automatic check_outputs(input string tag);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 10; c++)
        check($sformatf("%s_out[%0d][%0d]", tag, r, c), dout[r][c], expv[r][c]);
    check({tag, "_overflow"}, overflow, exp_ovf);
  endtask

  function automatic logic signed [31:0] rand_elem();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom);
      1:       return 32'($urandom_range(0, 7456540)) - 32'sd3728270;
      2:       return ($urandom_range(0, 1) != 0) ? 32'sd3728271 : -32'sd3728271;
      default: return 32'($urandom_range(0, 2000)) - 32'sd1000;
    endcase
  endfunction

  task automatic fill_random(input bit small_only);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 10; c++)
        din[r][c] = small_only ? 32'($urandom_range(0, 7456540)) - 32'sd3728270
                               : rand_elem();
  endtask

  task automatic fill_index();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 10; c++)
        din[r][c] = 32'(r * 10 + c);
  endtask

  // Pulses start for one edge, then counts edges until done (bounded)
  task automatic start_and_wait(output int l, output int b);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    l = 0;
    b = busy ? 1 : 0;
    while (!done && l < 300) begin
      @(posedge clk); #1;
      l++;
      if (busy) b++;
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 10; c++) begin
        din[r][c]  = '0;
        expv[r][c] = '0;
      end
    exp_ovf = 1'b0;

    // Reset state
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_out00", dout[0][0], 32'sd0);
    check("rst_out79", dout[7][9], 32'sd0);
    #10 rst_n = 1'b1;

    // Index pattern: latency, busy length, known values
    fill_index();
    model_pass();
    start_and_wait(lat, bcnt);
    check("idx_latency", lat, 81);
    check("idx_busy_cycles", bcnt, 81);
    check("idx_out79_const", dout[7][9], 32'sd45504);
    check("idx_out00_const", dout[0][0], 32'sd0);
    check_outputs("idx");
    @(posedge clk); #1;
    check("idx_done_one_cycle", done, 1'b0);

    // Largest non-saturating magnitudes
    fill_random(1'b1);
    din[0][0] = 32'sd3728270;
    din[0][1] = -32'sd3728270;
    model_pass();
    start_and_wait(lat, bcnt);
    check("bnd_latency", lat, 81);
    check("bnd_pos_const", dout[0][0], 32'sd2147483520);
    check("bnd_neg_const", dout[0][1], -32'sd2147483520);
    check_outputs("bnd");

    // Positive saturation
    din[0][0] = 32'sd3728271;
    model_pass();
    start_and_wait(lat, bcnt);
    check("satp_const", dout[0][0], 32'sh7FFFFFFF);
    check("satp_overflow_const", overflow, 1'b1);
    check_outputs("satp");

    // Negative saturation alone
    fill_random(1'b1);
    din[3][4] = -32'sd3728271;
    model_pass();
    start_and_wait(lat, bcnt);
    check("satn_const", dout[3][4], 32'sh80000000);
    check_outputs("satn");

    // All -1
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 10; c++)
        din[r][c] = -32'sd1;
    model_pass();
    start_and_wait(lat, bcnt);
    check("neg1_const", dout[5][5], 32'shFFFFFDC0);
    check_outputs("neg1");

    // Full-range random pass, leaves overflow set
    fill_random(1'b0);
    din[1][1] = 32'sh7FFFFFFF;
    model_pass();
    start_and_wait(lat, bcnt);
    check("rnd_latency", lat, 81);
    check_outputs("rnd");

    // Start re-pulsed mid-pass and on the done edge is ignored
    fill_index();
    model_pass();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("rep_overflow_cleared", overflow, 1'b0);
    check("rep_busy", busy, 1'b1);
    done_cnt = 0;
    done_at  = -1;
    for (int c = 1; c <= 120; c++) begin
      start = (c == 10 || c == 81);
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        done_cnt++;
        done_at = c;
      end
    end
    check("rep_done_count", done_cnt, 1);
    check("rep_done_edge", done_at, 81);
    check("rep_not_restarted", busy, 1'b0);
    check_outputs("rep");

    // Reset mid-pass aborts with no done
    fill_random(1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 10; c++)
        expv[r][c] = '0;
    exp_ovf = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check_outputs("abort");
    #3 rst_n = 1'b1;
    done_cnt = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    model_pass();
    start_and_wait(lat, bcnt);
    check("after_abort_latency", lat, 81);
    check_outputs("after_abort");

    // Start held high: three back-to-back passes
    @(posedge clk); #1;
    fill_random(1'b0);
    model_pass();
    start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!done && lat < 300) begin @(posedge clk); #1; lat++; end
    check("held0_latency", lat, 81);
    check_outputs("held0");
    for (int p = 1; p < 3; p++) begin
      fill_random(1'b0);
      model_pass();
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (!done && lat < 300);
      check($sformatf("held%0d_spacing", p), lat, 82);
      check_outputs($sformatf("held%0d", p));
    end
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
